// File: rtl/rob_commit.sv
// 4-wide reorder buffer with in-order retire of up to 4 contiguous done entries per cycle.
// Optional build macro ROB_PERF_CNT_EN adds the perf_retired / perf_stall counters.
module rob_commit #(
  parameter int DEPTH  = 32,
  parameter int PREG_W = 6,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [3:0]          disp_valid,
  output logic                disp_ready,
  input  logic [127:0]        disp_pc,
  input  logic [3:0]          disp_has_dest,
  input  logic [19:0]         disp_arch_rd,
  input  logic [4*PREG_W-1:0] disp_prd,
  output logic [4*IDX_W-1:0]  disp_rob_idx,
  input  logic [3:0]          wb_valid,
  input  logic [4*IDX_W-1:0]  wb_rob_idx,
  input  logic [127:0]        wb_data,
  output logic [7:0]          commit_valid,
  output logic [7:0]          rat_write_en,
  output logic [7:0]          rat_write_addr_0,
  output logic [7:0]          rat_write_addr_1,
  output logic [7:0]          rat_write_addr_2,
  output logic [7:0]          rat_write_addr_3,
  output logic [7:0]          rat_write_data_0,
  output logic [7:0]          rat_write_data_1,
  output logic [7:0]          rat_write_data_2,
  output logic [7:0]          rat_write_data_3,
  output logic [31:0]         reg_write_data_0,
  output logic [31:0]         reg_write_data_1,
  output logic [31:0]         reg_write_data_2,
  output logic [31:0]         reg_write_data_3,
  output logic [31:0]         pc0,
  output logic [31:0]         pc1,
  output logic [31:0]         pc2,
  output logic [31:0]         pc3,
  output logic [IDX_W:0]      rob_count
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [63:0]         perf_retired,
  output logic [63:0]         perf_stall
`endif
);

  localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - 4);

  logic              ent_valid [DEPTH];
  logic              ent_done  [DEPTH];
  logic [31:0]       ent_pc    [DEPTH];
  logic              ent_hd    [DEPTH];
  logic [4:0]        ent_rd    [DEPTH];
  logic [PREG_W-1:0] ent_prd   [DEPTH];
  logic [31:0]       ent_data  [DEPTH];

  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] head_k [4];
  logic [IDX_W-1:0] tail_k [4];
  logic [IDX_W-1:0] wb_idx [4];
  logic [3:0]       ret_mask;
  logic             ret_go;
  logic [2:0]       n_disp, n_ret;
  logic             disp_fire;
  logic [IDX_W:0]   disp_add, ret_sub;

  logic [3:0]  cm_valid, cm_rat_en;
  logic [7:0]  cm_rat_addr [4];
  logic [7:0]  cm_rat_data [4];
  logic [31:0] cm_data     [4];
  logic [31:0] cm_pc       [4];

  // Dispatch handshake: a group transfers on a clock edge where disp_ready and |disp_valid
  // are both high; disp_ready depends only on registered occupancy, never on this cycle's retire.
  assign disp_ready = (count <= READY_MAX);
  assign disp_fire  = disp_ready & (|disp_valid);
  assign n_disp     = 3'($countones(disp_valid));
  assign n_ret      = 3'($countones(ret_mask));
  assign disp_add   = disp_fire ? (IDX_W+1)'(n_disp) : '0;
  assign ret_sub    = (IDX_W+1)'(n_ret);

  always_comb begin
    disp_rob_idx = '0;
    ret_mask     = '0;
    ret_go       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tail_k[k] = tail + IDX_W'(k);
      head_k[k] = head + IDX_W'(k);
      wb_idx[k] = wb_rob_idx[k*IDX_W +: IDX_W];
      disp_rob_idx[k*IDX_W +: IDX_W] = tail_k[k];
      // Retire stops at the first entry that is not both valid and done.
      ret_go      = ret_go & ent_valid[head_k[k]] & ent_done[head_k[k]];
      ret_mask[k] = ret_go;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_done[i]  <= 1'b0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_done[i]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (wb_valid[k] && ent_valid[wb_idx[k]]) ent_done[wb_idx[k]] <= 1'b1;
      for (int k = 0; k < 4; k++)
        if (ret_mask[k]) begin
          ent_valid[head_k[k]] <= 1'b0;
          ent_done[head_k[k]]  <= 1'b0;
        end
      if (disp_fire)
        for (int k = 0; k < 4; k++)
          if (disp_valid[k]) begin
            ent_valid[tail_k[k]] <= 1'b1;
            ent_done[tail_k[k]]  <= 1'b0;
          end
    end
  end

  // Payload needs no reset: it is only observed through valid/done.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int k = 0; k < 4; k++)
        if (wb_valid[k] && ent_valid[wb_idx[k]]) ent_data[wb_idx[k]] <= wb_data[32*k +: 32];
      if (disp_fire)
        for (int k = 0; k < 4; k++)
          if (disp_valid[k]) begin
            ent_pc[tail_k[k]]  <= disp_pc[32*k +: 32];
            ent_hd[tail_k[k]]  <= disp_has_dest[k];
            ent_rd[tail_k[k]]  <= disp_arch_rd[5*k +: 5];
            ent_prd[tail_k[k]] <= disp_prd[PREG_W*k +: PREG_W];
          end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      cm_valid  <= '0;
      cm_rat_en <= '0;
      for (int k = 0; k < 4; k++) begin
        cm_rat_addr[k] <= '0;
        cm_rat_data[k] <= '0;
        cm_data[k]     <= '0;
        cm_pc[k]       <= '0;
      end
    end else begin
      head  <= head + IDX_W'(n_ret);
      tail  <= tail + IDX_W'(disp_add);
      count <= count + disp_add - ret_sub;
      for (int k = 0; k < 4; k++) begin
        cm_valid[k]    <= ret_mask[k];
        cm_rat_en[k]   <= ret_mask[k] & ent_hd[head_k[k]] & (ent_rd[head_k[k]] != 5'd0);
        cm_rat_addr[k] <= ret_mask[k] ? {3'b000, ent_rd[head_k[k]]} : 8'h00;
        cm_rat_data[k] <= ret_mask[k] ? 8'(ent_prd[head_k[k]]) : 8'h00;
        cm_data[k]     <= ret_mask[k] ? ent_data[head_k[k]] : 32'h0;
        cm_pc[k]       <= ret_mask[k] ? ent_pc[head_k[k]] : 32'h0;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      perf_retired <= perf_retired + 64'($countones(cm_valid));
      if (count != '0 && n_ret == 3'd0) perf_stall <= perf_stall + 64'd1;
    end
  end
`endif

  assign rob_count        = count;
  assign commit_valid     = {4'b0000, cm_valid};
  assign rat_write_en     = {4'b0000, cm_rat_en};
  assign rat_write_addr_0 = cm_rat_addr[0];
  assign rat_write_addr_1 = cm_rat_addr[1];
  assign rat_write_addr_2 = cm_rat_addr[2];
  assign rat_write_addr_3 = cm_rat_addr[3];
  assign rat_write_data_0 = cm_rat_data[0];
  assign rat_write_data_1 = cm_rat_data[1];
  assign rat_write_data_2 = cm_rat_data[2];
  assign rat_write_data_3 = cm_rat_data[3];
  assign reg_write_data_0 = cm_data[0];
  assign reg_write_data_1 = cm_data[1];
  assign reg_write_data_2 = cm_data[2];
  assign reg_write_data_3 = cm_data[3];
  assign pc0              = cm_pc[0];
  assign pc1              = cm_pc[1];
  assign pc2              = cm_pc[2];
  assign pc3              = cm_pc[3];

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: dispatch/writeback/retire, gaps, RAT enables, full/wrap,
// flush and asynchronous reset, with an in-order PC expectation queue.
module tb_rob_commit;
  localparam int DEPTH  = 32;
  localparam int PREG_W = 6;
  localparam int IDX_W  = 5;

  logic                clk = 1'b0;
  logic                rst, flush;
  logic [3:0]          disp_valid, disp_has_dest, wb_valid;
  logic                disp_ready;
  logic [127:0]        disp_pc, wb_data;
  logic [19:0]         disp_arch_rd;
  logic [4*PREG_W-1:0] disp_prd;
  logic [4*IDX_W-1:0]  disp_rob_idx, wb_rob_idx;
  logic [7:0]          commit_valid, rat_write_en;
  logic [7:0]          rat_write_addr_0, rat_write_addr_1, rat_write_addr_2, rat_write_addr_3;
  logic [7:0]          rat_write_data_0, rat_write_data_1, rat_write_data_2, rat_write_data_3;
  logic [31:0]         reg_write_data_0, reg_write_data_1, reg_write_data_2, reg_write_data_3;
  logic [31:0]         pc0, pc1, pc2, pc3;
  logic [IDX_W:0]      rob_count;

  int total = 0;
  int bad   = 0;
  int m_head = 0;
  int m_tail = 0;
  logic [31:0] exp_q[$];

  rob_commit #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
    .disp_has_dest(disp_has_dest), .disp_arch_rd(disp_arch_rd), .disp_prd(disp_prd),
    .disp_rob_idx(disp_rob_idx), .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx),
    .wb_data(wb_data), .commit_valid(commit_valid), .rat_write_en(rat_write_en),
    .rat_write_addr_0(rat_write_addr_0), .rat_write_addr_1(rat_write_addr_1),
    .rat_write_addr_2(rat_write_addr_2), .rat_write_addr_3(rat_write_addr_3),
    .rat_write_data_0(rat_write_data_0), .rat_write_data_1(rat_write_data_1),
    .rat_write_data_2(rat_write_data_2), .rat_write_data_3(rat_write_data_3),
    .reg_write_data_0(reg_write_data_0), .reg_write_data_1(reg_write_data_1),
    .reg_write_data_2(reg_write_data_2), .reg_write_data_3(reg_write_data_3),
    .pc0(pc0), .pc1(pc1), .pc2(pc2), .pc3(pc3), .rob_count(rob_count)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    disp_valid = '0; disp_has_dest = '0; disp_pc = '0; disp_arch_rd = '0; disp_prd = '0;
    wb_valid = '0; wb_rob_idx = '0; wb_data = '0;
  endtask

  task automatic drive_disp(input int n, input logic [31:0] pc_base, input logic [3:0] hd,
                            input logic [19:0] rd_vec, input int prd_base);
    logic [31:0] p;
    for (int k = 0; k < n; k++) begin
      p = pc_base + 32'(4 * k);
      disp_valid[k] = 1'b1;
      disp_pc[32*k +: 32] = p;
      disp_has_dest[k] = hd[k];
      disp_arch_rd[5*k +: 5] = rd_vec[5*k +: 5];
      disp_prd[PREG_W*k +: PREG_W] = PREG_W'(prd_base + k);
      exp_q.push_back(p);
    end
    m_tail = (m_tail + n) % DEPTH;
  endtask

  task automatic set_wb(input int port, input int idx, input logic [31:0] data);
    wb_valid[port] = 1'b1;
    wb_rob_idx[IDX_W*port +: IDX_W] = IDX_W'(idx);
    wb_data[32*port +: 32] = data;
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_pc(input int k);
    case (k)
      0: return pc0;
      1: return pc1;
      2: return pc2;
      default: return pc3;
    endcase
  endfunction

  task automatic check_idx(input string tag);
    logic [19:0] e;
    for (int k = 0; k < 4; k++) e[5*k +: 5] = 5'((m_tail + k) % DEPTH);
    check(tag, 64'(disp_rob_idx), 64'(e));
  endtask

  task automatic check_commit(input string tag, input logic [3:0] mask);
    logic [31:0] e;
    check({tag, "_commit_valid"}, 64'(commit_valid), {60'h0, mask});
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL %s_pc%0d observed=%0h expected=<empty queue>", tag, k, lane_pc(k));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_pc%0d", tag, k), 64'(lane_pc(k)), 64'(e));
        end
      end else begin
        check($sformatf("%s_pc%0d_idle", tag, k), 64'(lane_pc(k)), 64'h0);
      end
    end
    m_head = (m_head + $countones(mask)) % DEPTH;
  endtask

  task automatic wb_group(input string tag);
    for (int k = 0; k < 4; k++) set_wb(k, (m_head + k) % DEPTH, 32'h3000 + 32'(k));
    tick();
    clear_inputs();
    tick();
    check_commit(tag, 4'hF);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_commit_valid", 64'(commit_valid), 64'h0);
    check("rst_rat_en", 64'(rat_write_en), 64'h0);
    check("rst_pc0", 64'(pc0), 64'h0);
    check("rst_count", 64'(rob_count), 64'h0);
    check("rst_ready", 64'(disp_ready), 64'h1);
    check_idx("rst_idx");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Four-wide dispatch, writeback next cycle, commit three cycles after dispatch
    drive_disp(4, 32'h8000_0000, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 32);
    tick(); clear_inputs();
    check("t1_count", 64'(rob_count), 64'd4);
    check_idx("t1_idx");
    for (int k = 0; k < 4; k++) set_wb(k, k, 32'h100 + 32'(k));
    tick(); clear_inputs();
    check("t1_no_early_commit", 64'(commit_valid), 64'h0);
    tick();
    check_commit("t1", 4'hF);
    check("t1_rat_en", 64'(rat_write_en), 64'h0F);
    check("t1_rat_addr0", 64'(rat_write_addr_0), 64'd1);
    check("t1_rat_addr3", 64'(rat_write_addr_3), 64'd4);
    check("t1_rat_data0", 64'(rat_write_data_0), 64'd32);
    check("t1_rat_data3", 64'(rat_write_data_3), 64'd35);
    check("t1_reg_data2", 64'(reg_write_data_2), 64'h102);
    check("t1_count_after", 64'(rob_count), 64'd0);
    tick();
    check("t1_one_cycle", 64'(commit_valid), 64'h0);

    // Gap at head blocks retire; RAT enable masked by rd=0 / no dest; port priority
    drive_disp(3, 32'h1000, 4'b0011, {5'd0, 5'd7, 5'd0, 5'd3}, 10);
    tick(); clear_inputs();
    set_wb(0, 5, 32'h55); set_wb(1, 6, 32'h66);
    tick(); clear_inputs();
    tick();
    check("t2_gap_blocks", 64'(commit_valid), 64'h0);
    tick();
    check("t2_gap_still", 64'(commit_valid), 64'h0);
    set_wb(0, 4, 32'hAAAA); set_wb(3, 4, 32'hBBBB);
    tick(); clear_inputs();
    tick();
    check_commit("t2", 4'h7);
    check("t3_rat_en", 64'(rat_write_en), 64'h01);
    check("t2_rat_data0", 64'(rat_write_data_0), 64'd10);
    check("t2_port_prio", 64'(reg_write_data_0), 64'hBBBB);
    check("t2_reg_data1", 64'(reg_write_data_1), 64'h55);
    check("t2_reg_data2", 64'(reg_write_data_2), 64'h66);
    check("t2_reg_data3_idle", 64'(reg_write_data_3), 64'h0);

    // Fill to full across the index wrap, then drain in order
    for (int g = 0; g < 8; g++) begin
      check($sformatf("t4_ready_g%0d", g), 64'(disp_ready), 64'h1);
      check_idx($sformatf("t4_idx_g%0d", g));
      drive_disp(4, 32'h2000 + 32'(16 * g), 4'hF, {5'd8, 5'd7, 5'd6, 5'd5}, 1);
      tick(); clear_inputs();
    end
    check("t4_full_count", 64'(rob_count), 64'd32);
    check("t4_full_ready", 64'(disp_ready), 64'h0);
    disp_valid = 4'hF;
    tick(); clear_inputs();
    check("t4_blocked_count", 64'(rob_count), 64'd32);
    check_idx("t4_blocked_idx");
    wb_group("t4_g0");
    check("t4_count_28", 64'(rob_count), 64'd28);
    check("t4_ready_again", 64'(disp_ready), 64'h1);
    check_idx("t4_refill_idx");
    drive_disp(4, 32'h2080, 4'hF, {5'd8, 5'd7, 5'd6, 5'd5}, 1);
    tick(); clear_inputs();
    check("t4_refull", 64'(rob_count), 64'd32);
    for (int g = 1; g < 9; g++) wb_group($sformatf("t4_g%0d", g));
    check("t4_drained", 64'(rob_count), 64'd0);

    // Flush with 10 in flight, retire pending and same-cycle dispatch/writeback
    drive_disp(4, 32'h4000, 4'hF, {5'd1, 5'd1, 5'd1, 5'd1}, 2);
    tick(); clear_inputs();
    drive_disp(4, 32'h4010, 4'hF, {5'd1, 5'd1, 5'd1, 5'd1}, 2);
    tick(); clear_inputs();
    drive_disp(2, 32'h4020, 4'hF, {5'd1, 5'd1, 5'd1, 5'd1}, 2);
    for (int k = 0; k < 4; k++) set_wb(k, (m_head + k) % DEPTH, 32'h44);
    tick(); clear_inputs();
    check("t5_count_10", 64'(rob_count), 64'd10);
    flush = 1'b1;
    drive_disp(4, 32'h5000, 4'hF, {5'd1, 5'd1, 5'd1, 5'd1}, 2);
    set_wb(0, (m_head + 4) % DEPTH, 32'h45);
    tick(); clear_inputs();
    flush = 1'b0;
    exp_q.delete();
    m_head = 0; m_tail = 0;
    check("t5_count", 64'(rob_count), 64'd0);
    check("t5_commit", 64'(commit_valid), 64'h0);
    check_idx("t5_idx");
    check("t5_ready", 64'(disp_ready), 64'h1);
    tick();
    check("t5_commit_after", 64'(commit_valid), 64'h0);

    // Asynchronous reset mid-stream
    drive_disp(4, 32'h6000, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 20);
    tick(); clear_inputs();
    for (int k = 0; k < 4; k++) set_wb(k, k, 32'h600 + 32'(k));
    drive_disp(4, 32'h6010, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, 24);
    tick(); clear_inputs();
    tick();
    check_commit("t6_pre", 4'hF);
    check("t6_pre_count", 64'(rob_count), 64'd4);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    m_head = 0; m_tail = 0;
    check("t6_commit", 64'(commit_valid), 64'h0);
    check("t6_rat_en", 64'(rat_write_en), 64'h0);
    check("t6_pc0", 64'(pc0), 64'h0);
    check("t6_reg_data0", 64'(reg_write_data_0), 64'h0);
    check("t6_count", 64'(rob_count), 64'd0);
    check("t6_ready", 64'(disp_ready), 64'h1);
    check_idx("t6_idx");
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive_disp(1, 32'h7000, 4'h1, {5'd0, 5'd0, 5'd0, 5'd9}, 40);
    tick(); clear_inputs();
    check("t6_post_count", 64'(rob_count), 64'd1);
    set_wb(0, 0, 32'h77);
    tick(); clear_inputs();
    tick();
    check_commit("t6_post", 4'h1);
    check("t6_post_rat_en", 64'(rat_write_en), 64'h01);
    check("t6_post_rat_addr", 64'(rat_write_addr_0), 64'd9);
    check("t6_post_rat_data", 64'(rat_write_data_0), 64'd40);
    check("t6_post_reg_data", 64'(reg_write_data_0), 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
